reg_dump_reader: RTL

- Sequential readback engine for a bank of 32-bit register cells that have per-cell write-enable and read-enable, with each disabled cell driving 0.
- Asserts exactly one read-enable at a time and captures the OR-combined read bus.
- Streams each captured word to a consumer over a valid/ready handshake.
- Used by the CPU debug/trace path to dump register contents without touching the write side.

---
 rtl/reg_dump_reader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/reg_dump_reader.sv
// Readback engine: walks a bank of read-enabled register cells one at a time
// and streams each captured word to a consumer over valid/ready.
module reg_dump_reader #(
    parameter  int NREGS = 16,
    parameter  int W     = 32,
    localparam int IW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IW-1:0]    first_idx,
    input  logic [IW:0]      count,
    input  logic             abort,
    output logic [NREGS-1:0] en_r,
    input  logic [W-1:0]     rd_bus,
    output logic [W-1:0]     out_data,
    output logic [IW-1:0]    out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [IW:0]   NR   = (IW+1)'(NREGS);
    localparam logic [IW-1:0] LAST = IW'(NREGS - 1);

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic [IW:0]      r_remaining;
    logic [NREGS-1:0] r_en_r;
    logic [W-1:0]     r_out_data;
    logic [IW-1:0]    r_out_idx;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_done;

    logic [IW:0]      w_first_ext;
    logic [IW:0]      w_first_mod;
    logic [IW-1:0]    w_first;
    logic [IW:0]      w_count_clamp;
    logic [IW-1:0]    w_next_idx;
    logic             w_hs;

    function automatic logic [NREGS-1:0] f_onehot(input logic [IW-1:0] i);
        logic [NREGS-1:0] v;
        v = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (i == IW'(k)) v[k] = 1'b1;
        end
        return v;
    endfunction

    // Index space may exceed NREGS when it is not a power of two
    assign w_first_ext   = {1'b0, first_idx};
    assign w_first_mod   = (w_first_ext >= NR) ? (w_first_ext - NR) : w_first_ext;
    assign w_first       = w_first_mod[IW-1:0];
    assign w_count_clamp = (count > NR) ? NR : count;
    assign w_next_idx    = (r_idx == LAST) ? '0 : (r_idx + 1'b1);
    assign w_hs          = r_out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_remaining <= '0;
            r_en_r      <= '0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (w_count_clamp == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx       <= w_first;
                            r_remaining <= w_count_clamp;
                            r_en_r      <= f_onehot(w_first);
                            r_state     <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (abort) begin
                        r_state     <= S_IDLE;
                        r_en_r      <= '0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end else begin
                        r_out_data  <= rd_bus;
                        r_out_idx   <= r_idx;
                        r_out_valid <= 1'b1;
                        r_en_r      <= '0;
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Abort beats a same-cycle handshake: word counts as lost
                    if (abort) begin
                        r_state     <= S_IDLE;
                        r_en_r      <= '0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (w_hs) begin
                        r_out_valid <= 1'b0;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == (IW+1)'(1)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx   <= w_next_idx;
                            r_en_r  <= f_onehot(w_next_idx);
                            r_state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_en_r      <= '0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign en_r      = r_en_r;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
